// File: rtl/hc595_to_caseg.sv
// Receive-side 74HC595 link model: synchronizes ds/shcp/stcp/oe, rebuilds the
// shift/storage pair, checks frame length and decodes lit positions to digits.
module hc595_to_caseg #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ds,
  input  logic        shcp,
  input  logic        stcp,
  input  logic        oe,
  output logic [7:0]  sel_q,
  output logic [7:0]  seg_q,
  output logic        frame_vld,
  output logic        frame_err,
  output logic [31:0] digits,
  output logic [7:0]  dp_q
);

  localparam int unsigned LAST      = SYNC_STAGES - 1;
  localparam logic [4:0]  FRAME_CNT = 5'(FRAME_BITS);

  logic [SYNC_STAGES-1:0] ds_sr, shcp_sr, stcp_sr, oe_sr;
  logic                   shcp_d, stcp_d;
  logic [15:0]            shreg;
  logic [4:0]             bit_cnt;

  logic       shcp_rise, stcp_rise;
  logic       sel_onehot;
  logic [2:0] sel_idx;
  logic [3:0] seg_val;

  function automatic logic [3:0] seg_decode(input logic [6:0] p);
    logic [3:0] v;
    case (p)
      7'h40:   v = 4'h0;
      7'h79:   v = 4'h1;
      7'h24:   v = 4'h2;
      7'h30:   v = 4'h3;
      7'h19:   v = 4'h4;
      7'h12:   v = 4'h5;
      7'h02:   v = 4'h6;
      7'h78:   v = 4'h7;
      7'h00:   v = 4'h8;
      7'h10:   v = 4'h9;
      7'h7F:   v = 4'hA;
      default: v = 4'hF;
    endcase
    return v;
  endfunction

  // All four pins share the same chain depth so ds stays aligned with shcp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ds_sr   <= '0;
      shcp_sr <= '0;
      stcp_sr <= '0;
      oe_sr   <= '0;
      shcp_d  <= 1'b0;
      stcp_d  <= 1'b0;
    end else begin
      ds_sr   <= {ds_sr[SYNC_STAGES-2:0], ds};
      shcp_sr <= {shcp_sr[SYNC_STAGES-2:0], shcp};
      stcp_sr <= {stcp_sr[SYNC_STAGES-2:0], stcp};
      oe_sr   <= {oe_sr[SYNC_STAGES-2:0], oe};
      shcp_d  <= shcp_sr[LAST];
      stcp_d  <= stcp_sr[LAST];
    end
  end

  always_comb begin
    shcp_rise  = shcp_sr[LAST] & ~shcp_d;
    stcp_rise  = stcp_sr[LAST] & ~stcp_d;
    sel_onehot = (shreg[7:0] != '0) && ((shreg[7:0] & (shreg[7:0] - 8'd1)) == '0);
    sel_idx    = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (shreg[i]) sel_idx = i[2:0];
    end
    seg_val = seg_decode(shreg[14:8]);
  end

  // Latch and shift read the same pre-edge shreg/bit_cnt, so a coincident
  // shcp/stcp rise latches the old contents, as a real 595 does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      sel_q     <= 8'h00;
      seg_q     <= 8'hFF;
      frame_vld <= 1'b0;
      frame_err <= 1'b0;
      digits    <= 32'hAAAA_AAAA;
      dp_q      <= 8'h00;
    end else begin
      frame_vld <= 1'b0;
      if (shcp_rise) begin
        shreg <= {shreg[14:0], ds_sr[LAST]};
      end
      if (stcp_rise) begin
        sel_q     <= shreg[7:0];
        seg_q     <= shreg[15:8];
        frame_vld <= 1'b1;
        frame_err <= (bit_cnt != FRAME_CNT);
        bit_cnt   <= shcp_rise ? 5'd1 : 5'd0;
        if (!oe_sr[LAST] && sel_onehot) begin
          digits[{sel_idx, 2'b00} +: 4] <= seg_val;
          dp_q[sel_idx]                 <= ~shreg[15];
        end
      end else if (shcp_rise && bit_cnt != 5'd31) begin
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_hc595_to_caseg.sv
// Scoreboard bench for hc595_to_caseg: the driver pushes expected frames from a
// bit-history reference model; a negedge monitor pops on every frame_vld.
`timescale 1ns/1ps
module tb_hc595_to_caseg;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst, ds, shcp, stcp, oe;
  logic [7:0]  sel_q, seg_q, dp_q;
  logic        frame_vld, frame_err;
  logic [31:0] digits;

  hc595_to_caseg #(.SYNC_STAGES(SYNC), .FRAME_BITS(16)) dut (
    .clk(clk), .rst(rst), .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe),
    .sel_q(sel_q), .seg_q(seg_q), .frame_vld(frame_vld), .frame_err(frame_err),
    .digits(digits), .dp_q(dp_q)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  sel;
    logic [7:0]  seg;
    logic        err;
    logic [31:0] dig;
    logic [7:0]  dp;
    int          when;
  } exp_t;
  exp_t sbq[$];

  // Reference model: the last 16 shifted bits, a saturating shift count,
  // and the per-position digit/dp table.
  bit          hist[$];
  int          mcnt;
  logic [31:0] mdig;
  logic [7:0]  mdp;
  logic [6:0]  pats [11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h10, 7'h7F};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 11; i++) if (pats[i] == p) return 4'(i);
    return 4'hF;
  endfunction

  task automatic model_reset();
    hist.delete();
    mcnt = 0;
    mdig = 32'hAAAA_AAAA;
    mdp  = 8'h00;
  endtask

  task automatic model_shift(input bit b);
    hist.push_back(b);
    if (hist.size() > 16) void'(hist.pop_front());
    mcnt = (mcnt < 31) ? mcnt + 1 : 31;
  endtask

  task automatic model_latch(input logic oe_v);
    logic [15:0] w;
    exp_t e;
    int k;
    w = '0;
    foreach (hist[i]) w = {w[14:0], hist[i]};
    e.sel = w[7:0];
    e.seg = w[15:8];
    e.err = (mcnt != 16);
    mcnt  = 0;
    if (!oe_v && $countones(e.sel) == 1) begin
      k = 0;
      for (int i = 0; i < 8; i++) if (e.sel[i]) k = i;
      mdig[4*k +: 4] = ref_decode(e.seg[6:0]);
      mdp[k]         = ~e.seg[7];
    end
    e.dig  = mdig;
    e.dp   = mdp;
    e.when = cyc + SYNC + 1;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && frame_vld === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_frame_vld", 32'(frame_vld), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("latency_cycle", 32'(cyc), 32'(e.when));
        chk("sel_q", 32'(sel_q), 32'(e.sel));
        chk("seg_q", 32'(seg_q), 32'(e.seg));
        chk("frame_err", 32'(frame_err), 32'(e.err));
        chk("digits", digits, e.dig);
        chk("dp_q", 32'(dp_q), 32'(e.dp));
      end
    end
  end

  task automatic send_bit(input bit b);
    ds = b;
    repeat (2) @(negedge clk);
    shcp = 1'b1;
    model_shift(b);
    repeat (4) @(negedge clk);
    shcp = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_stcp();
    stcp = 1'b1;
    model_latch(oe);
    repeat (4) @(negedge clk);
    stcp = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic tied_bit(input bit b);
    ds = b;
    repeat (2) @(negedge clk);
    shcp = 1'b1;
    stcp = 1'b1;
    model_latch(oe);
    model_shift(b);
    repeat (4) @(negedge clk);
    shcp = 1'b0;
    stcp = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // nbits < 16 sends only the low nbits of {seg,sel}; extra bits go first.
  task automatic send_frame(input logic [7:0] seg, input logic [7:0] sel, input int nbits);
    logic [15:0] w;
    w = {seg, sel};
    for (int i = 16; i < nbits; i++) send_bit(1'($urandom));
    for (int i = ((nbits < 16) ? nbits : 16) - 1; i >= 0; i--) send_bit(w[i]);
    pulse_stcp();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sel_q"}, 32'(sel_q), 32'h00);
    chk({tag, "_seg_q"}, 32'(seg_q), 32'hFF);
    chk({tag, "_frame_vld"}, 32'(frame_vld), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_digits"}, digits, 32'hAAAA_AAAA);
    chk({tag, "_dp_q"}, 32'(dp_q), 32'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [7:0]  tpat [8] = '{8'h24, 8'h40, 8'h79, 8'h12, 8'h30, 8'h19, 8'h02, 8'h10};
    logic [31:0] held_dig;
    logic [7:0]  held_dp, seg, sel;
    int          nb;

    rst = 1'b0; ds = 1'b0; shcp = 1'b0; stcp = 1'b0; oe = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Nominal frame.
    send_frame(8'hC0, 8'h01, 16);
    chk("nominal_digit0", 32'(digits[3:0]), 32'h0);

    // Full time display, positions 7..0, dp lit on 6 and 4.
    for (int p = 7; p >= 0; p--) begin
      sel = 8'(1 << p);
      seg = {((p == 6 || p == 4) ? 1'b0 : 1'b1), tpat[7 - p][6:0]};
      send_frame(seg, sel, 16);
    end
    chk("time_digits", digits, 32'h2015_3469);
    chk("time_dp", 32'(dp_q), 32'h50);

    // Short frame, then a good one.
    send_frame(8'hA4, 8'h02, 15);
    chk("short_err", 32'(frame_err), 32'd1);
    send_frame(8'hA4, 8'h02, 16);
    chk("recover_err", 32'(frame_err), 32'd0);

    // oe high blocks digit capture.
    held_dig = digits;
    held_dp  = dp_q;
    oe = 1'b1;
    send_frame(8'hF9, 8'h08, 16);
    chk("oe_hold_digits", digits, held_dig);
    chk("oe_hold_dp", 32'(dp_q), 32'(held_dp));
    chk("oe_sel_q", 32'(sel_q), 32'h08);
    oe = 1'b0;
    send_frame(8'hF9, 8'h08, 16);
    chk("oe_low_digit3", 32'(digits[15:12]), 32'h1);

    // shcp and stcp tied together.
    for (int i = 0; i < 17; i++) tied_bit(1'($urandom));

    // Reset mid-frame.
    for (int i = 0; i < 8; i++) send_bit(1'($urandom));
    #3 rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'hC0, 8'h04, 16);
    chk("post_reset_err", 32'(frame_err), 32'd0);
    send_frame(8'h55, 8'h80, 16);
    chk("unknown_seg_digit7", 32'(digits[31:28]), 32'hF);

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      seg = ($urandom_range(3) == 0) ? 8'($urandom)
                                     : {1'($urandom), pats[$urandom_range(10)]};
      sel = ($urandom_range(4) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(7));
      oe  = ($urandom_range(3) == 0);
      nb  = ($urandom_range(4) == 0) ? $urandom_range(18, 13) : 16;
      send_frame(seg, sel, nb);
    end
    oe = 1'b0;

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hc595_to_caseg.md
Name: hc595_to_caseg

Overview:
- Receive-side model of the 74HC595 serial display link; it is the far end of the ds/shcp/stcp/oe stream produced by the segment-display serializer.
- Samples the four link pins in the clk domain and rebuilds the 16-bit shift/storage register pair.
- Recovers sel/seg, checks frame length, and decodes each lit position back into a 4-bit digit.
- Used as a bench monitor and as the receive half of a remote display board.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on every link input; minimum 2.
- FRAME_BITS, 16, number of shcp rising edges expected between stcp rising edges.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous reset, active low.
- ds  input  1  serial data, sampled on shcp rising edge.
- shcp  input  1  shift clock; rising edge shifts.
- stcp  input  1  storage clock; rising edge latches.
- oe  input  1  output enable, active low.
- sel_q  output  8  latched position select, one-hot, active high; sel_q[7] is the leftmost digit.
- seg_q  output  8  latched segments {dp,g,f,e,d,c,b,a}, common anode, active low.
- frame_vld  output  1  one-clk pulse on every detected stcp rising edge.
- frame_err  output  1  high when the last frame had a shift count different from FRAME_BITS.
- digits  output  32  nibble k (bits 4k+3:4k) is the last decoded value for position k.
- dp_q  output  8  bit k is the last decimal-point state for position k (1 = lit).

Behaviour:
- Reset (rst low, asynchronous): all synchronizers and shreg go to 0; sel_q=8'h00; seg_q=8'hFF; frame_vld=0; frame_err=0; digits=32'hAAAA_AAAA (all blank); dp_q=8'h00; bit counter=0.
- Synchronization:
  - ds, shcp, stcp and oe each pass through a SYNC_STAGES flop chain, so all four stay time-aligned.
  - Edge detect compares the last sync stage with one extra delay flop.
  - The link requires shcp/stcp high and low times of at least 2 clk periods and ds stable for at least 2 clk around each shcp rise. Faster links are out of scope.
- Shift path:
  - On a detected shcp rise: shreg <= {shreg[14:0], ds_sync}.
  - The bit counter increments and saturates at 31.
  - Transmit order: seg[7] first, seg[0], then sel[7], sel[0] last.
- Latch path, on a detected stcp rise:
  - sel_q <= shreg[7:0]; seg_q <= shreg[15:8].
  - frame_vld pulses high for 1 clk.
  - frame_err <= (count != FRAME_BITS).
  - The counter clears to 0.
  - Latency: sel_q and seg_q change on the (SYNC_STAGES+1)th clk rising edge after the first edge that samples stcp high.
- Simultaneous shcp and stcp rise (same sample):
  - The latch takes the pre-shift shreg, matching a real 595.
  - frame_err uses the pre-shift count.
  - The shift still happens and the counter is set to 1.
- Digit capture, in the same cycle as the latch and only when synchronized oe=0 and shreg[7:0] is exactly one-hot:
  - The index k is the position of the set bit; nibble k and dp_q[k] are updated. dp_q[k] = ~shreg[15].
  - Decode of shreg[14:8] (g..a): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 7F->A (blank).
  - Any other pattern decodes to F.
  - If sel is zero or not one-hot, or oe is high: digits and dp_q hold, while sel_q, seg_q and frame_err still update.
- frame_err is not sticky; it reflects the most recent frame only.
- Reset mid-frame discards the partial shreg and the count. The first stcp after reset flags frame_err unless exactly FRAME_BITS shifts were seen after reset.

Test Plan:
- Nominal frame, oe=0: send seg=8'hC0, sel=8'h01 as 16 bits at shcp = clk/8, then pulse stcp -> sel_q=01, seg_q=C0, frame_vld 1 clk at latency 3, frame_err=0, digits[3:0]=0, dp_q[0]=0.
- Full time display: eight frames for positions 7..0 with patterns 24,40,79,12,30,19,02,10 and dp lit on positions 6 and 4 -> digits=32'h2015_3469, dp_q=8'h50, no frame_err.
- Short frame: 15 shifts then stcp -> frame_err=1, sel_q/seg_q reflect shreg. The next correct 16-bit frame -> frame_err=0.
- oe high: valid frame sel=08, seg=F9 with oe=1 -> sel_q=08, seg_q=F9, digits and dp_q unchanged. Repeat with oe=0 -> digits[15:12]=1.
- Tied shcp/stcp: drive both from the same pin pattern for 17 edges -> each latch returns the pre-shift value; first stcp flags frame_err; sel_q/seg_q lag shreg by one shift.
- Async reset asserted after 8 shifts, released, then a full frame -> outputs at reset values during rst low. The post-reset frame latches correctly with frame_err=0. Unknown seg 8'h55 on sel=80 -> digits[31:28]=F.
